// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the fetch and decode stages.
//   NOP        - instruction word used for an empty IF/ID slot.
//   pcsrc_e    - next-PC select encoding driven by decode control.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,  // pc + 4
    PCSRC_BR  = 2'b01,  // branch target
    PCSRC_JR  = 2'b10,  // register target
    PCSRC_J   = 2'b11   // jump target
  } pcsrc_e;

endpackage

// File: rtl/pipe_if_stage_dffe32.sv
// dffe32: 32-bit register with load enable and asynchronous active-high
// clear to a caller-supplied value.
// Ports:
//   clk    - rising-edge clock
//   clr    - asynchronous clear, active high
//   clrval - value loaded while clr is high
//   e      - load enable
//   d      - data in
//   q      - registered data out
module dffe32 (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] clrval,
  input  logic        e,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] r_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q <= clrval;
    end else if (e) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction-fetch stage. Holds the PC, selects the next PC
// from decode control and registers {pc+4, instruction, valid} into IF/ID.
// Optional build macro IF_FLUSH_EN: when defined, the instruction fetched in
// a redirect cycle is squashed (bubble); when undefined it is kept as a
// branch delay slot.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-high reset
//   nostall  - 0 freezes PC and IF/ID
//   pcsource - next-PC select (see pipe_pkg::pcsrc_e)
//   bpc/da/jpc - branch / jr / j targets, loaded verbatim
//   ins      - instruction memory data for address pc
//   pc       - fetch address
//   dpc4     - IF/ID pc+4
//   inst     - IF/ID instruction
//   dvalid   - IF/ID slot holds a real instruction
module pipe_if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  input  logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  logic [31:0] w_pc_p0;
  logic [31:0] w_pc4_p0;
  logic [31:0] w_npc_p0;
  logic [31:0] w_inst_d_p0;
  logic        w_dvalid_d_p0;
  logic [31:0] w_dpc4_p1;
  logic [31:0] w_inst_p1;
  logic        r_dvalid_p1;

  // Fetch: next-PC selection, 32-bit wrapping increment.
  assign w_pc4_p0 = w_pc_p0 + 32'd4;

  always_comb begin
    w_npc_p0 = w_pc4_p0;
    case (pcsrc_e'(pcsource))
      PCSRC_SEQ: w_npc_p0 = w_pc4_p0;
      PCSRC_BR:  w_npc_p0 = bpc;
      PCSRC_JR:  w_npc_p0 = da;
      PCSRC_J:   w_npc_p0 = jpc;
      default:   w_npc_p0 = w_pc4_p0;
    endcase
  end

`ifdef IF_FLUSH_EN
  // Redirect squashes the instruction fetched alongside it.
  always_comb begin
    w_inst_d_p0   = ins;
    w_dvalid_d_p0 = 1'b1;
    if (pcsrc_e'(pcsource) != PCSRC_SEQ) begin
      w_inst_d_p0   = NOP;
      w_dvalid_d_p0 = 1'b0;
    end
  end
`else
  // Delay slot: the fetched instruction always enters IF/ID.
  assign w_inst_d_p0   = ins;
  assign w_dvalid_d_p0 = 1'b1;
`endif

  dffe32 u_pc (
    .clk    (clock),
    .clr    (reset),
    .clrval (RESET_PC),
    .e      (nostall),
    .d      (w_npc_p0),
    .q      (w_pc_p0)
  );

  // IF/ID boundary.
  dffe32 u_dpc4 (
    .clk    (clock),
    .clr    (reset),
    .clrval (32'h0000_0000),
    .e      (nostall),
    .d      (w_pc4_p0),
    .q      (w_dpc4_p1)
  );

  dffe32 u_inst (
    .clk    (clock),
    .clr    (reset),
    .clrval (NOP),
    .e      (nostall),
    .d      (w_inst_d_p0),
    .q      (w_inst_p1)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dvalid_p1 <= 1'b0;
    end else if (nostall) begin
      r_dvalid_p1 <= w_dvalid_d_p0;
    end
  end

  assign pc     = w_pc_p0;
  assign dpc4   = w_dpc4_p1;
  assign inst   = w_inst_p1;
  assign dvalid = r_dvalid_p1;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed vector table plus hand sequences for
// asynchronous reset and a non-zero RESET_PC instance.
module tb_pipe_if_stage;

  logic        clock;
  logic        reset;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc, ins;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;
  logic [31:0] pc2, dpc42, inst2;
  logic        dvalid2;

  int total = 0;
  int bad   = 0;

`ifdef IF_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  pipe_if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clock(clock), .reset(reset), .nostall(nostall), .pcsource(pcsource),
    .bpc(bpc), .da(da), .jpc(jpc), .ins(ins),
    .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid)
  );

  pipe_if_stage #(.RESET_PC(32'hBFC0_0000)) u_dut2 (
    .clock(clock), .reset(reset), .nostall(nostall), .pcsource(pcsource),
    .bpc(bpc), .da(da), .jpc(jpc), .ins(ins),
    .pc(pc2), .dpc4(dpc42), .inst(inst2), .dvalid(dvalid2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ns;
    logic [1:0]  src;
    logic [31:0] bpc;
    logic [31:0] da;
    logic [31:0] jpc;
    logic [31:0] ins;
    logic [31:0] exp_pc;
    logic [31:0] exp_dpc4;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] exp_inst;
    logic        exp_dv;

    //            ns  src   bpc            da            jpc            ins            pc             dpc4
    vecs[0]  = '{1'b1, 2'd0, 32'h0,        32'h0,        32'h0,         32'hA000_0000, 32'h0000_0004, 32'h0000_0004};
    vecs[1]  = '{1'b1, 2'd0, 32'h0,        32'h0,        32'h0,         32'hA000_0001, 32'h0000_0008, 32'h0000_0008};
    vecs[2]  = '{1'b1, 2'd3, 32'h0,        32'h0,        32'h10,        32'hA000_0002, 32'h0000_0010, 32'h0000_000C};
    vecs[3]  = '{1'b0, 2'd1, 32'h40,       32'h0,        32'h0,         32'hA000_0003, 32'h0000_0010, 32'h0000_000C};
    vecs[4]  = '{1'b0, 2'd1, 32'h40,       32'h0,        32'h0,         32'hA000_0004, 32'h0000_0010, 32'h0000_000C};
    vecs[5]  = '{1'b1, 2'd0, 32'h40,       32'h0,        32'h0,         32'hA000_0005, 32'h0000_0014, 32'h0000_0014};
    vecs[6]  = '{1'b1, 2'd3, 32'h0,        32'h0,        32'h20,        32'hA000_0006, 32'h0000_0020, 32'h0000_0018};
    vecs[7]  = '{1'b1, 2'd1, 32'h100,      32'h0,        32'h0,         32'hA000_0007, 32'h0000_0100, 32'h0000_0024};
    vecs[8]  = '{1'b1, 2'd2, 32'h0,        32'h3C,       32'h0,         32'hA000_0008, 32'h0000_003C, 32'h0000_0104};
    vecs[9]  = '{1'b1, 2'd3, 32'h0,        32'h0,        32'h0040_0000, 32'hA000_0009, 32'h0040_0000, 32'h0000_0040};
    vecs[10] = '{1'b1, 2'd0, 32'h0,        32'h0,        32'h0,         32'hA000_000A, 32'h0040_0004, 32'h0040_0004};
    vecs[11] = '{1'b1, 2'd1, 32'hFFFF_FFFC,32'h0,        32'h0,         32'hA000_000B, 32'hFFFF_FFFC, 32'h0040_0008};
    vecs[12] = '{1'b1, 2'd0, 32'h0,        32'h0,        32'h0,         32'hA000_000C, 32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{1'b1, 2'd1, 32'h80,       32'h0,        32'h0,         32'hA000_000D, 32'h0000_0080, 32'h0000_0004};
    vecs[14] = '{1'b1, 2'd2, 32'h0,        32'h83,       32'h0,         32'hA000_000E, 32'h0000_0083, 32'h0000_0084};
    vecs[15] = '{1'b1, 2'd1, 32'h80,       32'h0,        32'h0,         32'hA000_000F, 32'h0000_0080, 32'h0000_0087};

    reset = 1'b1; nostall = 1'b1; pcsource = 2'd1;
    bpc = 32'h200; da = 32'h0; jpc = 32'h0; ins = 32'hDEAD_BEEF;

    // Reset held across edges with a redirect pending.
    repeat (2) @(negedge clock);
    check("rst_pc",     pc,     32'h0);
    check("rst_dpc4",   dpc4,   32'h0);
    check("rst_inst",   inst,   32'h0);
    check("rst_dvalid", {31'd0, dvalid}, 32'h0);
    check("rst_pc2",    pc2,    32'hBFC0_0000);

    reset = 1'b0; pcsource = 2'd0;
    exp_inst = 32'h0; exp_dv = 1'b0;

    for (int i = 0; i < 16; i++) begin
      nostall = vecs[i].ns; pcsource = vecs[i].src;
      bpc = vecs[i].bpc; da = vecs[i].da; jpc = vecs[i].jpc; ins = vecs[i].ins;
      if (vecs[i].ns) begin
        if (FLUSH && vecs[i].src != 2'd0) begin
          exp_inst = 32'h0; exp_dv = 1'b0;
        end else begin
          exp_inst = vecs[i].ins; exp_dv = 1'b1;
        end
      end
      @(negedge clock);
      check($sformatf("v%0d_pc", i),     pc,   vecs[i].exp_pc);
      check($sformatf("v%0d_dpc4", i),   dpc4, vecs[i].exp_dpc4);
      check($sformatf("v%0d_inst", i),   inst, exp_inst);
      check($sformatf("v%0d_dvalid", i), {31'd0, dvalid}, {31'd0, exp_dv});
      if (i == 0) begin
        check("rp2_pc",   pc2,   32'hBFC0_0004);
        check("rp2_dpc4", dpc42, 32'hBFC0_0004);
      end
    end

    // Stalled at 0x80: async reset pulse between edges.
    nostall = 1'b0; pcsource = 2'd1; bpc = 32'h300; ins = 32'h1111_1111;
    @(negedge clock);
    check("stall80_pc", pc, 32'h80);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_pc",     pc,   32'h0);
    check("arst_dpc4",   dpc4, 32'h0);
    check("arst_inst",   inst, 32'h0);
    check("arst_dvalid", {31'd0, dvalid}, 32'h0);
    #1 reset = 1'b0;
    // First edge after release fetches from RESET_PC.
    @(negedge clock);
    nostall = 1'b1; pcsource = 2'd0; ins = 32'h2222_2222;
    @(negedge clock);
    check("post_pc",     pc,   32'h4);
    check("post_dpc4",   dpc4, 32'h4);
    check("post_inst",   inst, 32'h2222_2222);
    check("post_dvalid", {31'd0, dvalid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL provide port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port nostall  input  1  from decode control; 0 freezes the PC and the IF/ID register.
REQ-005 SHALL provide port pcsource  input  2  next-PC select from decode control.
REQ-006 SHALL provide port bpc  input  32  branch target.
REQ-007 SHALL provide port da  input  32  jr target (forwarded rs value).
REQ-008 SHALL provide port jpc  input  32  j/jal target.
REQ-009 SHALL provide port ins  input  32  instruction word returned combinationally by instruction memory for address pc.
REQ-010 SHALL provide port pc  output  32  current fetch address to instruction memory.
REQ-011 SHALL provide port dpc4  output  32  IF/ID-registered PC+4.
REQ-012 SHALL provide port inst  output  32  IF/ID-registered instruction.
REQ-013 SHALL provide port dvalid  output  1  IF/ID slot holds a fetched instruction (0 = bubble).

Function
REQ-014 SHALL compute pc4 = pc + 4 in 32-bit arithmetic, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-015 SHALL select npc as follows: pcsource 00 -> pc4; 01 -> bpc; 10 -> da; 11 -> jpc.
REQ-016 SHALL, on a rising edge with nostall=1, load pc<=npc, dpc4<=pc4, inst<=ins and dvalid<=1, except as modified by REQ-024.
REQ-017 SHALL, on a rising edge with nostall=0, hold pc, dpc4, inst and dvalid unchanged; pcsource SHALL be ignored in that cycle (stall wins over redirect).
REQ-018 SHALL have a fetch latency of one cycle: ins sampled at edge N appears on inst after edge N.
REQ-019 SHALL keep pc, dpc4, inst and dvalid purely registered (no combinational path from inputs to outputs).
REQ-020 SHALL not check alignment; bpc, da and jpc SHALL be loaded verbatim.

Reset
REQ-021 SHALL, while reset=1 and regardless of clock, force pc=RESET_PC, dpc4=0, inst=32'h0000_0000 (nop), and dvalid=0.
REQ-022 SHALL, on reset deassertion mid-stream, discard any pending stall or redirect; the first edge after deassertion fetches from RESET_PC.

Configuration
REQ-023 SHALL, when macro IF_FLUSH_EN is undefined, implement a branch delay slot: the instruction fetched in a redirect cycle enters IF/ID normally.
REQ-024 SHALL, when IF_FLUSH_EN is defined, on an edge with nostall=1 and pcsource!=00, load inst<=32'h0 and dvalid<=0 (dpc4 still <= pc4) while pc<=npc.

Structure
REQ-025 SHALL take the NOP constant and the PCSRC_SEQ/BR/JR/J encodings (00/01/10/11) from shared package pipe_pkg, also used by the decode stage.
REQ-026 SHALL build pc, dpc4 and inst from sub-module dffe32 (32-bit register with enable and asynchronous active-high clear to a given value).

Verification
REQ-027 SHALL cover the reset case: assert reset with RESET_PC=0 -> pc=0, inst=0, dvalid=0; release and clock twice with pcsource=00 -> pc=8, dpc4=8.
REQ-028 SHALL cover a stall: at pc=0x10, nostall=0 for 2 cycles with pcsource=01, bpc=0x40 -> pc stays 0x10, inst/dpc4 unchanged; nostall=1 -> pc advances.
REQ-029 SHALL cover a branch: at pc=0x20, pcsource=01, bpc=0x100 -> pc=0x100, dpc4=0x24; inst=ins, dvalid=1 without IF_FLUSH_EN; inst=0, dvalid=0 with IF_FLUSH_EN.
REQ-030 SHALL cover jr and j: pcsource=10, da=0x3C -> pc=0x3C; pcsource=11, jpc=0x0040_0000 -> pc=0x0040_0000.
REQ-031 SHALL cover wrap: pc=0xFFFF_FFFC, pcsource=00 -> pc=0x0, dpc4=0x0.
REQ-032 SHALL cover asynchronous reset mid-cycle: reset pulse between edges while stalled at pc=0x80 -> pc=RESET_PC immediately, before the next edge.
